mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
Parametrised successor to the CPU request unit. Arbitrates the instruction-fetch channel and the data load/store channel onto one shared single-port memory bus. Holds each granted request on the bus until the memory completes it, then returns registered read data with a one-cycle ready pulse. Adds selectable priority, byte enables, wait-state handling and a bus-timeout abort.

Parameters:
ADDR_W, 32, address width of both channels and the memory bus
DATA_W, 32, data width; must be a multiple of 8
DATA_PRIORITY, 1, 1 = data always wins a conflict; 0 = alternate grants on conflict
TIMEOUT, 255, max cycles a strobe may wait on m_busy before abort; 0 disables the timeout

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
i_req  in  1  fetch request, level, held until i_ready
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  registered fetch data
i_ready  out  1  one-cycle fetch-complete pulse
d_ren  in  1  load request, level
d_wen  in  1  store request, level; wins over d_ren if both high
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_be  in  DATA_W/8  store byte enables
d_rdata  out  DATA_W  registered load data
d_ready  out  1  one-cycle data-complete pulse
m_ren  out  1  memory read strobe
m_wen  out  1  memory write strobe
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_be  out  DATA_W/8  memory byte enables; all ones on reads
m_rdata  in  DATA_W  memory read data, valid in the completion cycle
m_busy  in  1  memory stall; completion = strobe high and m_busy low
err  out  1  sticky timeout flag

Behaviour:
- Reset (async, nRST=0): FSM=IDLE; all outputs 0, including m_ren, m_wen, m_addr, m_wdata, m_be, i_rdata, d_rdata, both ready pulses and err. A transaction in flight is dropped immediately with no ready pulse.
- FSM states: IDLE, IBUS, DBUS.
- IDLE: computes eligible requests. A channel is ineligible in the cycle its own ready pulse is high, which prevents a double issue from a held level request.
  - One eligible channel: grant it.
  - Both eligible, DATA_PRIORITY=1: grant data.
  - Both eligible, DATA_PRIORITY=0: grant the channel not granted last; the last-grant register resets to "instruction", so data wins the first conflict.
  - On grant, register address, write data and byte enables into the m_* outputs and assert the strobe next cycle. Move to IBUS or DBUS.
- IBUS/DBUS: strobe and m_* outputs stay stable.
  - When m_busy=0: capture m_rdata into i_rdata or d_rdata (loads and fetches only; d_rdata holds its value on a store). Drop the strobe, pulse the channel ready next cycle, return to IDLE.
- Minimum latency: request seen in cycle 0, strobe in cycle 1, ready in cycle 2. Each m_busy cycle adds one cycle.
- Back-to-back: a new grant can be made in the IDLE cycle that coincides with the previous ready pulse, but only for the other channel.
- Timeout (TIMEOUT>0): a counter clears on grant and increments on each strobe cycle with m_busy=1.
  - On reaching TIMEOUT: drop the strobe, set err, pulse the channel ready next cycle with rdata = 0, return to IDLE.
  - err stays set until reset.
- Requests deasserted while granted do not cancel the bus access. Its completion still pulses ready.
- Channel inputs are sampled only at grant. Later changes do not affect the bus.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_busy=0, m_rdata=0xDEADBEEF -> m_ren=1 and m_addr=0x100 in cycle 1; i_ready=1 and i_rdata=0xDEADBEEF in cycle 2; no second m_ren while i_req is still held through cycle 2.
- Conflict, DATA_PRIORITY=1: i_req and d_wen in the same cycle, d_addr=0x2000, d_wdata=0x12345678, d_be=0b0011 -> write issued first with m_be=0b0011; d_ready pulses; the fetch issues in the following cycle.
- Wait states: load with m_busy high for 3 cycles -> m_ren held 4 cycles with stable m_addr; d_ready arrives in cycle 5.
- Timeout, TIMEOUT=4, m_busy stuck at 1 -> strobe drops after 4 wait cycles; d_ready=1 with d_rdata=0; err=1 and remains set.
- Alternation, DATA_PRIORITY=0: both channels requesting continuously -> grants go data, instr, data, instr.
- Reset mid-op: nRST low during DBUS wait -> m_wen=0 with no clock edge; no d_ready; after release, the pending i_req is served normally.

Source files
------------

// File: rtl/mem_request_arbiter.sv
// Arbitrates the fetch and load/store channels onto one single-port memory bus,
// holding each access until the memory completes it or it times out.
module mem_request_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int DATA_PRIORITY = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ready,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ready,
    output logic                m_ren,
    output logic                m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_busy,
    output logic                err
);
    localparam int BE_W = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit DPRI = (DATA_PRIORITY != 0);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS} state_e;

    state_e              state_q, state_d;
    logic                m_ren_q, m_ren_d, m_wen_q, m_wen_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic [BE_W-1:0]     m_be_q, m_be_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic                i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic                err_q, err_d;
    logic                last_d_q, last_d_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                i_elig, d_elig, pick_d, done, tmo;

    // A channel whose ready pulse is high is still holding its old level request.
    assign i_elig = i_req & ~i_ready_q;
    assign d_elig = (d_ren | d_wen) & ~d_ready_q;
    assign pick_d = d_elig & (~i_elig | DPRI | ~last_d_q);
    assign done   = ~m_busy;
    assign tmo    = (TIMEOUT != 0) && m_busy && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        m_ren_d   = m_ren_q;
        m_wen_d   = m_wen_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        err_d     = err_q;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_d) begin
                    state_d   = DBUS;
                    last_d_d  = 1'b1;
                    m_wen_d   = d_wen;
                    m_ren_d   = ~d_wen;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wen ? d_wdata : '0;
                    m_be_d    = d_wen ? d_be : '1;
                end else if (i_elig) begin
                    state_d   = IBUS;
                    last_d_d  = 1'b0;
                    m_ren_d   = 1'b1;
                    m_wen_d   = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    m_be_d    = '1;
                end
            end
            IBUS, DBUS: begin
                if (done || tmo) begin
                    state_d = IDLE;
                    m_ren_d = 1'b0;
                    m_wen_d = 1'b0;
                    err_d   = err_q | tmo;
                    if (state_q == IBUS) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = tmo ? '0 : m_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (tmo)          d_rdata_d = '0;
                        else if (m_ren_q) d_rdata_d = m_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            m_ren_q   <= 1'b0;
            m_wen_q   <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_be_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
            last_d_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            m_ren_q   <= m_ren_d;
            m_wen_q   <= m_wen_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
            last_d_q  <= last_d_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_ren   = m_ren_q;
    assign m_wen   = m_wen_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_be    = m_be_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign err     = err_q;
endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench: per-cycle vector table on a data-priority instance, plus
// hand-written reset and alternation sequences (second instance, DATA_PRIORITY=0).
module tb_mem_request_arbiter;
    logic        CLK = 1'b0;
    logic        nRST = 1'b0, rst2_n = 1'b0;
    logic        i_req = 0, d_ren = 0, d_wen = 0, m_busy = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
    logic [3:0]  d_be = 0;

    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, m_ren, m_wen, err;
    logic [3:0]  m_be;
    logic [31:0] i_rdata2, d_rdata2, m_addr2, m_wdata2;
    logic        i_ready2, d_ready2, m_ren2, m_wen2, err2;
    logic [3:0]  m_be2;

    int checks = 0, failures = 0;

    always #5 CLK = ~CLK;

    mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(1), .TIMEOUT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata), .m_busy(m_busy), .err(err));

    mem_request_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIORITY(0), .TIMEOUT(4)) dut2 (
        .CLK(CLK), .nRST(rst2_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata2), .i_ready(i_ready2),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata2), .d_ready(d_ready2),
        .m_ren(m_ren2), .m_wen(m_wen2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_be(m_be2),
        .m_rdata(m_rdata), .m_busy(m_busy), .err(err2));

    typedef struct {
        logic        ireq;  logic [31:0] iaddr;
        logic        dren;  logic        dwen;  logic [31:0] daddr;
        logic [31:0] dwdata; logic [3:0] dbe;
        logic        busy;  logic [31:0] rdata;
        logic        ren;   logic        wen;   logic [31:0] addr; logic [3:0] be;
        logic        ir;    logic        dr;
        logic [31:0] ird;   logic [31:0] drd;   logic        err;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mkv(
        input logic ireq, input logic [31:0] iaddr, input logic dren, input logic dwen,
        input logic [31:0] daddr, input logic [31:0] dwdata, input logic [3:0] dbe,
        input logic busy, input logic [31:0] rdata,
        input logic ren, input logic wen, input logic [31:0] addr, input logic [3:0] be,
        input logic ir, input logic dr, input logic [31:0] ird, input logic [31:0] drd,
        input logic e);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr; v.dren = dren; v.dwen = dwen; v.daddr = daddr;
        v.dwdata = dwdata; v.dbe = dbe; v.busy = busy; v.rdata = rdata;
        v.ren = ren; v.wen = wen; v.addr = addr; v.be = be; v.ir = ir; v.dr = dr;
        v.ird = ird; v.drd = drd; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // fetch; write-vs-fetch conflict; load with 3 waits; timeout; post-timeout fetch
        vecs[0]  = mkv(1,'h100,0,0,0,0,0, 0,0,            1,0,'h100,4'hF, 0,0,0,0,0);
        vecs[1]  = mkv(1,'h100,0,0,0,0,0, 0,'hDEADBEEF,   0,0,0,0, 1,0,'hDEADBEEF,0,0);
        vecs[2]  = mkv(1,'h100,0,0,0,0,0, 0,'hDEADBEEF,   0,0,0,0, 0,0,'hDEADBEEF,0,0);
        vecs[3]  = mkv(0,0,0,0,0,0,0,     0,0,            0,0,0,0, 0,0,'hDEADBEEF,0,0);
        vecs[4]  = mkv(1,'h104,0,1,'h2000,'h12345678,4'b0011, 0,0,
                       0,1,'h2000,4'b0011, 0,0,'hDEADBEEF,0,0);
        vecs[5]  = mkv(1,'h104,0,1,'h2000,'h12345678,4'b0011, 0,'hBAD0BAD0,
                       0,0,0,0, 0,1,'hDEADBEEF,0,0);
        vecs[6]  = mkv(1,'h104,0,1,'h2000,'h12345678,4'b0011, 0,0,
                       1,0,'h104,4'hF, 0,0,'hDEADBEEF,0,0);
        vecs[7]  = mkv(1,'h104,0,0,0,0,0, 0,'hCAFEF00D,   0,0,0,0, 1,0,'hCAFEF00D,0,0);
        vecs[8]  = mkv(0,0,0,0,0,0,0,     0,0,            0,0,0,0, 0,0,'hCAFEF00D,0,0);
        vecs[9]  = mkv(0,0,1,0,'h300,0,0, 0,0,            1,0,'h300,4'hF, 0,0,'hCAFEF00D,0,0);
        vecs[10] = mkv(0,0,1,0,'h300,0,0, 1,0,            1,0,'h300,4'hF, 0,0,'hCAFEF00D,0,0);
        vecs[11] = mkv(0,0,1,0,'h300,0,0, 1,0,            1,0,'h300,4'hF, 0,0,'hCAFEF00D,0,0);
        vecs[12] = mkv(0,0,1,0,'h300,0,0, 1,0,            1,0,'h300,4'hF, 0,0,'hCAFEF00D,0,0);
        vecs[13] = mkv(0,0,0,0,0,0,0,     0,'hA5A50001,   0,0,0,0, 0,1,'hCAFEF00D,'hA5A50001,0);
        vecs[14] = mkv(0,0,0,0,0,0,0,     0,0,            0,0,0,0, 0,0,'hCAFEF00D,'hA5A50001,0);
        vecs[15] = mkv(0,0,1,0,'h400,0,0, 1,0,            1,0,'h400,4'hF, 0,0,'hCAFEF00D,'hA5A50001,0);
        vecs[16] = mkv(0,0,0,0,0,0,0,     1,0,            1,0,'h400,4'hF, 0,0,'hCAFEF00D,'hA5A50001,0);
        vecs[17] = mkv(0,0,0,0,0,0,0,     1,0,            1,0,'h400,4'hF, 0,0,'hCAFEF00D,'hA5A50001,0);
        vecs[18] = mkv(0,0,0,0,0,0,0,     1,0,            1,0,'h400,4'hF, 0,0,'hCAFEF00D,'hA5A50001,0);
        vecs[19] = mkv(0,0,0,0,0,0,0,     1,'h77777777,   0,0,0,0, 0,1,'hCAFEF00D,0,1);
        vecs[20] = mkv(0,0,0,0,0,0,0,     0,0,            0,0,0,0, 0,0,'hCAFEF00D,0,1);
        vecs[21] = mkv(1,'h108,0,0,0,0,0, 0,0,            1,0,'h108,4'hF, 0,0,'hCAFEF00D,0,1);
        vecs[22] = mkv(0,0,0,0,0,0,0,     0,'h11112222,   0,0,0,0, 1,0,'h11112222,0,1);
        vecs[23] = mkv(0,0,0,0,0,0,0,     0,0,            0,0,0,0, 0,0,'h11112222,0,1);

        step; step;
        chk("rst_m_ren", m_ren, 0);     chk("rst_m_wen", m_wen, 0);
        chk("rst_m_addr", m_addr, 0);   chk("rst_m_wdata", m_wdata, 0);
        chk("rst_m_be", m_be, 0);       chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0); chk("rst_i_ready", i_ready, 0);
        chk("rst_d_ready", d_ready, 0); chk("rst_err", err, 0);
        nRST = 1'b1;

        for (int k = 0; k < 24; k++) begin
            i_req = vecs[k].ireq; i_addr = vecs[k].iaddr;
            d_ren = vecs[k].dren; d_wen = vecs[k].dwen; d_addr = vecs[k].daddr;
            d_wdata = vecs[k].dwdata; d_be = vecs[k].dbe;
            m_busy = vecs[k].busy; m_rdata = vecs[k].rdata;
            step;
            chk($sformatf("v%0d_m_ren", k), m_ren, vecs[k].ren);
            chk($sformatf("v%0d_m_wen", k), m_wen, vecs[k].wen);
            if (vecs[k].ren || vecs[k].wen) begin
                chk($sformatf("v%0d_m_addr", k), m_addr, vecs[k].addr);
                chk($sformatf("v%0d_m_be", k), m_be, vecs[k].be);
            end
            if (vecs[k].wen)
                chk($sformatf("v%0d_m_wdata", k), m_wdata, vecs[k].dwdata);
            chk($sformatf("v%0d_i_ready", k), i_ready, vecs[k].ir);
            chk($sformatf("v%0d_d_ready", k), d_ready, vecs[k].dr);
            chk($sformatf("v%0d_i_rdata", k), i_rdata, vecs[k].ird);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, vecs[k].drd);
            chk($sformatf("v%0d_err", k), err, vecs[k].err);
        end

        // Reset in the middle of a stalled store; pending fetch served afterwards.
        d_wen = 1; d_addr = 'h500; d_wdata = 'h55; d_be = 4'hF; m_busy = 1;
        step; chk("rm_wen_grant", m_wen, 1);
        d_wen = 0;
        step; chk("rm_wen_held", m_wen, 1);
        i_req = 1; i_addr = 'h600;
        #2 nRST = 1'b0;
        #1;
        chk("rm_async_wen", m_wen, 0);
        chk("rm_async_addr", m_addr, 0);
        chk("rm_async_err", err, 0);
        chk("rm_async_dready", d_ready, 0);
        step; chk("rm_hold_dready", d_ready, 0);
        nRST = 1'b1; m_busy = 0;
        step; chk("rm_fetch_ren", m_ren, 1); chk("rm_fetch_addr", m_addr, 'h600);
        chk("rm_no_dready", d_ready, 0);
        i_req = 0; m_rdata = 'h600D;
        step; chk("rm_fetch_ready", i_ready, 1); chk("rm_fetch_rdata", i_rdata, 'h600D);
        chk("rm_no_dready2", d_ready, 0);

        // Alternating grants with DATA_PRIORITY=0.
        i_req = 1; i_addr = 'h700; d_ren = 1; d_wen = 0; d_addr = 'h800; m_busy = 0;
        rst2_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step;
            if (e % 2 == 1) begin
                chk($sformatf("alt%0d_ren", e), m_ren2, 1);
                chk($sformatf("alt%0d_addr", e), m_addr2, (e % 4 == 1) ? 32'h800 : 32'h700);
            end else if (e % 4 == 2) begin
                chk($sformatf("alt%0d_dready", e), d_ready2, 1);
            end else begin
                chk($sformatf("alt%0d_iready", e), i_ready2, 1);
            end
        end
        step; chk("alt9_addr", m_addr2, 'h800);
        i_req = 0; d_ren = 0;
        step; chk("alt10_dready", d_ready2, 1);
        step; chk("alt11_idle", m_ren2, 0);
        i_req = 1; d_ren = 1;
        step; chk("dp0_fresh_conflict_ren", m_ren2, 1);
        chk("dp0_fresh_conflict_addr", m_addr2, 'h700);
        i_req = 0; d_ren = 0;
        step;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
